// File: rtl/sha256_arb.sv
// Round-robin arbiter and sequencer sharing one sha256_top core between N_REQ
// message streams; each digest is returned over a ready/valid port with its owner's ID.
module sha256_arb #(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*32-1:0] req_data,
    input  logic [N_REQ-1:0]    req_last,
    input  logic [N_REQ*2-1:0]  req_last_sz,
    output logic [N_REQ-1:0]    req_ready,
    output logic                core_m_valid,
    output logic [31:0]         core_m_data,
    output logic                core_m_last,
    output logic [1:0]          core_m_last_sz,
    input  logic                core_m_ready,
    input  logic                core_s_valid,
    input  logic [255:0]        core_s_data,
    output logic                dig_valid,
    output logic [255:0]        dig_data,
    output logic [ID_W-1:0]     dig_id,
    input  logic                dig_ready,
    output logic                busy,
    output logic [ID_W-1:0]     gnt_id
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] gnt_q, gnt_d;
    logic [255:0]    dig_data_q, dig_data_d;
    logic [ID_W-1:0] dig_id_q, dig_id_d;

    logic            arb_hit;
    logic [ID_W-1:0] arb_idx;
    logic [ID_W-1:0] arb_cand;

    // Search starts just past the last grant, so the previous owner ends up last.
    // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        arb_hit  = 1'b0;
        arb_idx  = gnt_q;
        arb_cand = gnt_q;
        for (int k = 1; k <= N_REQ; k++) begin
            arb_cand = ID_W'((int'(gnt_q) + k) % N_REQ);
            if (!arb_hit && req_valid[arb_cand]) begin
                arb_hit = 1'b1;
                arb_idx = arb_cand;
            end
        end
    end

    // Locked stream is passed straight through to the core; only valid/ready are gated.
    always_comb begin
        core_m_data    = req_data[32*gnt_q +: 32];
        core_m_last    = req_last[gnt_q];
        core_m_last_sz = req_last_sz[2*gnt_q +: 2];
        core_m_valid   = (state_q == ST_FEED) && req_valid[gnt_q];
        req_ready      = '0;
        if (state_q == ST_FEED) begin
            req_ready[gnt_q] = core_m_ready;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        dig_data_d = dig_data_q;
        dig_id_d   = dig_id_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_hit) begin
                    gnt_d   = arb_idx;
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                if (core_m_valid && core_m_ready && core_m_last) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_s_valid) begin
                    dig_data_d = core_s_data;
                    dig_id_d   = gnt_q;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (dig_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= ID_W'(N_REQ - 1);
            dig_data_q <= '0;
            dig_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            dig_data_q <= dig_data_d;
            dig_id_q   <= dig_id_d;
        end
    end

    assign dig_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign gnt_id    = gnt_q;
    assign dig_data  = dig_data_q;
    assign dig_id    = dig_id_q;

endmodule
